// File: rtl/even_parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Define PARITY_ODD_EN to send odd parity instead of the default even parity.
module even_parity_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               tx_q, tx_d;
  logic               accept;
  logic               bit_done;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
`ifdef PARITY_ODD_EN
    return ~^d;
`else
    return ^d;
`endif
  endfunction

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign parity   = parity_q;
  assign accept   = in_valid && in_ready;
  assign bit_done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_d    = bit_q;
    cnt_d    = bit_done ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) begin
          shift_d  = in_data;
          parity_d = calc_parity(in_data);
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the line level lands on the same edge as the state change
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

endmodule
